// File: rtl/hazard3_dbus_pmp_gate.sv
// hazard3_dbus_pmp_gate
//   PMP gate on the load/store AHB-Lite path. Each core address phase is
//   offered to the PMP data-side query; a killed transfer is kept off the
//   system bus and answered locally with a two-cycle ERROR response, and its
//   address/direction are captured for trap and debug logic.
// Ports
//   clk, rst_n          clock, async active-low reset
//   m_mode              core privilege (M-mode) for the PMP query
//   c_h*                core-side AHB-Lite manager port
//   pmp_addr/write/m_mode, pmp_kill   PMP query and same-cycle verdict
//   s_h*                system-side AHB-Lite port
//   fault_pulse         one-cycle strobe in the cycle after a kill is accepted
//   fault_addr/write    details of the most recent killed transfer
module hazard3_dbus_pmp_gate #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_mode,
  input  logic [W_ADDR-1:0] c_haddr,
  input  logic [1:0]        c_htrans,
  input  logic              c_hwrite,
  input  logic [2:0]        c_hsize,
  input  logic [W_DATA-1:0] c_hwdata,
  output logic              c_hready,
  output logic              c_hresp,
  output logic [W_DATA-1:0] c_hrdata,
  output logic [W_ADDR-1:0] pmp_addr,
  output logic              pmp_write,
  output logic              pmp_m_mode,
  input  logic              pmp_kill,
  output logic [W_ADDR-1:0] s_haddr,
  output logic [1:0]        s_htrans,
  output logic              s_hwrite,
  output logic [2:0]        s_hsize,
  output logic [W_DATA-1:0] s_hwdata,
  input  logic              s_hready,
  input  logic              s_hresp,
  input  logic [W_DATA-1:0] s_hrdata,
  output logic              fault_pulse,
  output logic [W_ADDR-1:0] fault_addr,
  output logic              fault_write
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  state_t              state_q, state_d;
  logic                fault_pulse_q, fault_pulse_d;
  logic [W_ADDR-1:0]   fault_addr_q, fault_addr_d;
  logic                fault_write_q, fault_write_d;

  logic kill_now;
  logic accept;

  // The PMP query is presented unconditionally; only active transfers matter.
  assign pmp_addr   = c_haddr;
  assign pmp_write  = c_hwrite;
  assign pmp_m_mode = m_mode;

  // In ERR1 the core may already be presenting its next transfer, but its
  // verdict is not consumed until ERR2 where that transfer is accepted.
  assign kill_now = c_htrans[1] && pmp_kill && (state_q != ST_ERR1);
  assign accept   = c_htrans[1] && c_hready;

  assign s_haddr  = c_haddr;
  assign s_hwrite = c_hwrite;
  assign s_hsize  = c_hsize;
  assign s_hwdata = c_hwdata;
  // The system bus sees hready high during ERR1 (its data phase is IDLE),
  // so a held core transfer must be masked there or it would be sampled.
  assign s_htrans = (state_q == ST_ERR1 || kill_now) ? HTRANS_IDLE : c_htrans;

  always_comb begin
    state_d       = state_q;
    c_hready      = s_hready;
    c_hresp       = s_hresp;
    c_hrdata      = s_hrdata;
    fault_pulse_d = 1'b0;
    fault_addr_d  = fault_addr_q;
    fault_write_d = fault_write_q;

    case (state_q)
      ST_ERR1: begin
        c_hready = 1'b0;
        c_hresp  = 1'b1;
        c_hrdata = '0;
        state_d  = ST_ERR2;
      end
      ST_ERR2: begin
        c_hready = 1'b1;
        c_hresp  = 1'b1;
        c_hrdata = '0;
        state_d  = ST_IDLE;
      end
      default: ;
    endcase

    // While a stalled system data phase holds c_hready low, a pending kill
    // is not accepted and the state is left alone.
    if (accept && kill_now) begin
      state_d       = ST_ERR1;
      fault_pulse_d = 1'b1;
      fault_addr_d  = c_haddr;
      fault_write_d = c_hwrite;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      fault_pulse_q <= 1'b0;
      fault_addr_q  <= '0;
      fault_write_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fault_pulse_q <= fault_pulse_d;
      fault_addr_q  <= fault_addr_d;
      fault_write_q <= fault_write_d;
    end
  end

  assign fault_pulse = fault_pulse_q;
  assign fault_addr  = fault_addr_q;
  assign fault_write = fault_write_q;

endmodule

// File: tb/tb_hazard3_dbus_pmp_gate.sv
module tb_hazard3_dbus_pmp_gate;
  localparam int W_ADDR = 32;
  localparam int W_DATA = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              m_mode = 1'b0;
  logic [W_ADDR-1:0] c_haddr = '0;
  logic [1:0]        c_htrans = 2'b00;
  logic              c_hwrite = 1'b0;
  logic [2:0]        c_hsize = 3'd2;
  logic [W_DATA-1:0] c_hwdata = '0;
  logic              c_hready, c_hresp;
  logic [W_DATA-1:0] c_hrdata;
  logic [W_ADDR-1:0] pmp_addr;
  logic              pmp_write, pmp_m_mode;
  logic              pmp_kill = 1'b0;
  logic [W_ADDR-1:0] s_haddr;
  logic [1:0]        s_htrans;
  logic              s_hwrite;
  logic [2:0]        s_hsize;
  logic [W_DATA-1:0] s_hwdata;
  logic              s_hready = 1'b1;
  logic              s_hresp = 1'b0;
  logic [W_DATA-1:0] s_hrdata = '0;
  logic              fault_pulse;
  logic [W_ADDR-1:0] fault_addr;
  logic              fault_write;

  int n_cmp = 0;
  int n_err = 0;

  hazard3_dbus_pmp_gate #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) dut (
    .clk(clk), .rst_n(rst_n), .m_mode(m_mode),
    .c_haddr(c_haddr), .c_htrans(c_htrans), .c_hwrite(c_hwrite),
    .c_hsize(c_hsize), .c_hwdata(c_hwdata),
    .c_hready(c_hready), .c_hresp(c_hresp), .c_hrdata(c_hrdata),
    .pmp_addr(pmp_addr), .pmp_write(pmp_write), .pmp_m_mode(pmp_m_mode),
    .pmp_kill(pmp_kill),
    .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite),
    .s_hsize(s_hsize), .s_hwdata(s_hwdata),
    .s_hready(s_hready), .s_hresp(s_hresp), .s_hrdata(s_hrdata),
    .fault_pulse(fault_pulse), .fault_addr(fault_addr), .fault_write(fault_write)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive point: 1 time unit after a rising edge. Checks happen at #4 later.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] tr, input logic [31:0] a, input logic wr, input logic kill);
    c_htrans = tr; c_haddr = a; c_hwrite = wr; pmp_kill = kill;
  endtask

  typedef struct {
    logic [1:0]  htrans;
    logic [31:0] addr;
    logic        write;
    logic        kill;
    logic        shready;
    logic        shresp;
    logic [31:0] shrdata;
    logic [1:0]  exp_strans;
    logic        exp_hready;
    logic        exp_hresp;
    logic [31:0] exp_hrdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // Pass-through in IDLE; none of these rows is an accepted kill.
    vecs[0] = '{2'b00, 32'h0000_0010, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1111_1111, 2'b00, 1'b1, 1'b0, 32'h1111_1111};
    vecs[1] = '{2'b10, 32'h0000_0020, 1'b1, 1'b0, 1'b1, 1'b0, 32'hAAAA_5555, 2'b10, 1'b1, 1'b0, 32'hAAAA_5555};
    vecs[2] = '{2'b11, 32'h0000_0024, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 2'b11, 1'b0, 1'b0, 32'h0000_0001};
    vecs[3] = '{2'b01, 32'h0000_0028, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0002, 2'b01, 1'b1, 1'b1, 32'h0000_0002};
    vecs[4] = '{2'b10, 32'h0000_0030, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0003, 2'b00, 1'b0, 1'b1, 32'h0000_0003};
    vecs[5] = '{2'b11, 32'h0000_0034, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0004, 2'b11, 1'b1, 1'b0, 32'h0000_0004};

    // Reset state
    #3;
    chk("rst fault_pulse", {31'b0, fault_pulse}, 32'd0);
    chk("rst fault_addr", fault_addr, 32'd0);
    chk("rst fault_write", {31'b0, fault_write}, 32'd0);
    chk("rst c_hready follows", {31'b0, c_hready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    next_cyc();

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].htrans, vecs[i].addr, vecs[i].write, vecs[i].kill);
      s_hready = vecs[i].shready; s_hresp = vecs[i].shresp; s_hrdata = vecs[i].shrdata;
      m_mode = i[0];
      #4;
      chk($sformatf("vec%0d s_htrans", i), {30'b0, s_htrans}, {30'b0, vecs[i].exp_strans});
      chk($sformatf("vec%0d c_hready", i), {31'b0, c_hready}, {31'b0, vecs[i].exp_hready});
      chk($sformatf("vec%0d c_hresp", i), {31'b0, c_hresp}, {31'b0, vecs[i].exp_hresp});
      chk($sformatf("vec%0d c_hrdata", i), c_hrdata, vecs[i].exp_hrdata);
      chk($sformatf("vec%0d s_haddr", i), s_haddr, vecs[i].addr);
      chk($sformatf("vec%0d pmp_addr", i), pmp_addr, vecs[i].addr);
      chk($sformatf("vec%0d pmp_write", i), {31'b0, pmp_write}, {31'b0, vecs[i].write});
      chk($sformatf("vec%0d pmp_m_mode", i), {31'b0, pmp_m_mode}, {31'b0, i[0]});
      next_cyc();
    end
    s_hready = 1'b1; s_hresp = 1'b0;
    drive(2'b00, 32'h0, 1'b0, 1'b0);
    next_cyc();

    // 1: passed read
    drive(2'b10, 32'h2000_0000, 1'b0, 1'b0);
    #4 chk("t1 s_htrans", {30'b0, s_htrans}, 32'd2);
    next_cyc();
    drive(2'b00, 32'h0, 1'b0, 1'b0); s_hrdata = 32'hDEAD_BEEF;
    #4;
    chk("t1 c_hready", {31'b0, c_hready}, 32'd1);
    chk("t1 c_hresp", {31'b0, c_hresp}, 32'd0);
    chk("t1 c_hrdata", c_hrdata, 32'hDEAD_BEEF);
    next_cyc();

    // 2: killed write
    drive(2'b10, 32'h0000_1000, 1'b1, 1'b1);
    #4 chk("t2 s_htrans", {30'b0, s_htrans}, 32'd0);
    next_cyc();
    drive(2'b00, 32'h0, 1'b0, 1'b0);
    #4;
    chk("t2 err1 c_hready", {31'b0, c_hready}, 32'd0);
    chk("t2 err1 c_hresp", {31'b0, c_hresp}, 32'd1);
    chk("t2 err1 c_hrdata", c_hrdata, 32'd0);
    chk("t2 fault_pulse", {31'b0, fault_pulse}, 32'd1);
    chk("t2 fault_addr", fault_addr, 32'h0000_1000);
    chk("t2 fault_write", {31'b0, fault_write}, 32'd1);
    next_cyc();
    #4;
    chk("t2 err2 c_hready", {31'b0, c_hready}, 32'd1);
    chk("t2 err2 c_hresp", {31'b0, c_hresp}, 32'd1);
    chk("t2 err2 fault_pulse", {31'b0, fault_pulse}, 32'd0);
    next_cyc();

    // 3: core holds NONSEQ through ERR1, forwarded from ERR2
    drive(2'b10, 32'h0000_1000, 1'b1, 1'b1);
    next_cyc();
    drive(2'b10, 32'h3000_0000, 1'b0, 1'b0);
    #4;
    chk("t3 err1 s_htrans", {30'b0, s_htrans}, 32'd0);
    chk("t3 err1 c_hready", {31'b0, c_hready}, 32'd0);
    next_cyc();
    #4;
    chk("t3 err2 s_htrans", {30'b0, s_htrans}, 32'd2);
    chk("t3 err2 c_hready", {31'b0, c_hready}, 32'd1);
    chk("t3 err2 c_hresp", {31'b0, c_hresp}, 32'd1);
    next_cyc();
    drive(2'b00, 32'h0, 1'b0, 1'b0); s_hrdata = 32'h0BAD_F00D;
    #4;
    chk("t3 idle c_hresp", {31'b0, c_hresp}, 32'd0);
    chk("t3 idle c_hrdata", c_hrdata, 32'h0BAD_F00D);
    next_cyc();

    // 4: back-to-back kills
    drive(2'b10, 32'h0000_0040, 1'b1, 1'b1);
    next_cyc();
    drive(2'b00, 32'h0, 1'b0, 1'b0);
    next_cyc();
    drive(2'b10, 32'h0000_0044, 1'b0, 1'b1);
    #4;
    chk("t4 err2 s_htrans", {30'b0, s_htrans}, 32'd0);
    chk("t4 err2 c_hresp", {31'b0, c_hresp}, 32'd1);
    next_cyc();
    drive(2'b00, 32'h0, 1'b0, 1'b0);
    #4;
    chk("t4 fault_pulse", {31'b0, fault_pulse}, 32'd1);
    chk("t4 fault_addr", fault_addr, 32'h0000_0044);
    chk("t4 fault_write", {31'b0, fault_write}, 32'd0);
    chk("t4 err1 c_hready", {31'b0, c_hready}, 32'd0);
    next_cyc();
    #4;
    chk("t4 err2 c_hready", {31'b0, c_hready}, 32'd1);
    chk("t4 err2 c_hresp", {31'b0, c_hresp}, 32'd1);
    next_cyc();

    // 5: kill while previous data phase is stalled
    drive(2'b10, 32'h0000_0100, 1'b0, 1'b0);
    next_cyc();
    drive(2'b10, 32'h0000_0200, 1'b1, 1'b1); s_hready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #4;
      chk($sformatf("t5 stall%0d s_htrans", k), {30'b0, s_htrans}, 32'd0);
      chk($sformatf("t5 stall%0d c_hready", k), {31'b0, c_hready}, 32'd0);
      chk($sformatf("t5 stall%0d c_hresp", k), {31'b0, c_hresp}, 32'd0);
      chk($sformatf("t5 stall%0d fault_pulse", k), {31'b0, fault_pulse}, 32'd0);
      next_cyc();
    end
    s_hready = 1'b1;
    #4;
    chk("t5 release c_hready", {31'b0, c_hready}, 32'd1);
    chk("t5 release s_htrans", {30'b0, s_htrans}, 32'd0);
    next_cyc();
    drive(2'b00, 32'h0, 1'b0, 1'b0);
    #4;
    chk("t5 err1 c_hready", {31'b0, c_hready}, 32'd0);
    chk("t5 err1 c_hresp", {31'b0, c_hresp}, 32'd1);
    chk("t5 fault_pulse", {31'b0, fault_pulse}, 32'd1);
    chk("t5 fault_addr", fault_addr, 32'h0000_0200);
    next_cyc();
    #4;
    chk("t5 err2 c_hready", {31'b0, c_hready}, 32'd1);
    chk("t5 err2 c_hresp", {31'b0, c_hresp}, 32'd1);
    next_cyc();

    // 6: reset during ERR1
    drive(2'b10, 32'h0000_0500, 1'b1, 1'b1);
    next_cyc();
    drive(2'b00, 32'h0, 1'b0, 1'b0);
    #1 chk("t6 err1 fault_pulse", {31'b0, fault_pulse}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6 rst fault_pulse", {31'b0, fault_pulse}, 32'd0);
    chk("t6 rst fault_addr", fault_addr, 32'd0);
    chk("t6 rst fault_write", {31'b0, fault_write}, 32'd0);
    chk("t6 rst c_hready", {31'b0, c_hready}, 32'd1);
    chk("t6 rst c_hresp", {31'b0, c_hresp}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cyc();
    drive(2'b10, 32'h0000_0600, 1'b0, 1'b0);
    #4 chk("t6 read s_htrans", {30'b0, s_htrans}, 32'd2);
    next_cyc();
    drive(2'b00, 32'h0, 1'b0, 1'b0); s_hrdata = 32'h1234_5678;
    #4;
    chk("t6 read c_hready", {31'b0, c_hready}, 32'd1);
    chk("t6 read c_hresp", {31'b0, c_hresp}, 32'd0);
    chk("t6 read c_hrdata", c_hrdata, 32'h1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hazard3_dbus_pmp_gate.md
Name: hazard3_dbus_pmp_gate

Overview:
- Sits on the load/store AHB-Lite path between the core's data-bus manager port and the system bus.
- Forwards each address phase to the PMP data-side query (address, write, M-mode) and consumes the returned kill.
- A killed transfer never reaches the system bus. The gate answers it locally with a standard two-cycle AHB-Lite ERROR response, and captures the faulting address for trap/debug logic.

Parameters:
- W_ADDR, 32, address width.
- W_DATA, 32, data width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- m_mode  input  1  core currently in M-mode.
- c_haddr  input  W_ADDR  core-side address.
- c_htrans  input  2  core-side transfer type.
- c_hwrite  input  1  core-side write.
- c_hsize  input  3  core-side size.
- c_hwdata  input  W_DATA  core-side write data.
- c_hready  output  1  ready to core.
- c_hresp  output  1  response to core.
- c_hrdata  output  W_DATA  read data to core.
- pmp_addr  output  W_ADDR  PMP query address (= c_haddr).
- pmp_write  output  1  PMP query write (= c_hwrite).
- pmp_m_mode  output  1  PMP query mode (= m_mode).
- pmp_kill  input  1  PMP verdict, combinational in the same cycle.
- s_haddr  output  W_ADDR  system address.
- s_htrans  output  2  system transfer type.
- s_hwrite  output  1  system write.
- s_hsize  output  3  system size.
- s_hwdata  output  W_DATA  system write data.
- s_hready  input  1  system ready.
- s_hresp  input  1  system response.
- s_hrdata  input  W_DATA  system read data.
- fault_pulse  output  1  one-cycle strobe when a killed transfer is accepted.
- fault_addr  output  W_ADDR  address of the most recent killed transfer.
- fault_write  output  1  write flag of the most recent killed transfer.

Behaviour:

Acceptance and kill:
- Address phase is accepted when c_htrans[1] && c_hready.
- kill_now = c_htrans[1] && pmp_kill && (state != ERR1).

Pass-through:
- s_haddr, s_hwrite, s_hsize, s_hwdata pass through combinationally.
- s_htrans = (state == ERR1 || kill_now) ? IDLE : c_htrans.
  - In ERR1, s_htrans is forced IDLE even if the core holds non-IDLE. The system bus sees hready high in that cycle and would otherwise sample the transfer.

State machine (IDLE, ERR1, ERR2):
- IDLE:
  - c_hready = s_hready, c_hresp = s_hresp, c_hrdata = s_hrdata.
  - On an accepted kill_now (c_hready high), go to ERR1.
- ERR1:
  - c_hready = 0, c_hresp = 1, c_hrdata = 0.
  - Always go to ERR2.
- ERR2:
  - c_hready = 1, c_hresp = 1, c_hrdata = 0.
  - A new address phase in ERR2 is accepted. If kill_now, go to ERR1; otherwise go to IDLE and forward the transfer.
- The system data phase is IDLE during ERR1/ERR2, so s_hready/s_hresp are ignored there.

Kill timing:
- A kill while a previous system data phase is stalled (s_hready = 0) does not change state until that phase completes.
- s_htrans is nonetheless forced IDLE in those cycles.

Fault capture:
- On each accepted kill, register fault_addr = c_haddr and fault_write = c_hwrite.
- fault_pulse is high for exactly the cycle after acceptance (coincides with ERR1).

Reset:
- Async reset to state IDLE, fault_pulse = 0, fault_addr = 0, fault_write = 0.
- Combinational outputs in IDLE follow the system bus.
- Reset mid-error abandons the response.

Latency:
- Zero added cycles on passed transfers.
- Exactly 2 data-phase cycles for killed transfers.
- No back-to-back IDLE insertion.

PMP query outputs:
- pmp_* are valid every cycle; the gate qualifies them with c_htrans[1].

Test Plan:
1. Read 0x2000_0000, pmp_kill=0, s_hready=1, s_hrdata=0xDEADBEEF -> s_htrans=NONSEQ same cycle; core sees hready=1, hresp=0, hrdata=0xDEADBEEF next cycle.
2. Write 0x0000_1000, pmp_kill=1 -> s_htrans=IDLE; core sees (hready,hresp) = (0,1) then (1,1); fault_pulse=1 for one cycle; fault_addr=0x0000_1000; fault_write=1.
3. Core holds NONSEQ to 0x3000_0000 (pmp_kill=0) during ERR1 -> s_htrans=IDLE in ERR1. The transfer is accepted in ERR2 and forwarded NONSEQ; state returns to IDLE.
4. Back-to-back killed transfers: kill in ERR2 to 0x44 -> ERR1 again; fault_addr=0x44; second fault_pulse fires.
5. Previous read stalled with s_hready=0 for 3 cycles while the next address is killed -> no state change until s_hready=1; s_htrans stays IDLE; then ERR1/ERR2 follow.
6. Assert rst_n low during ERR1 -> state IDLE and fault_* cleared immediately; after release, a normal passed read completes.
